// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_receiver
//  Purpose  : PS/2 device-to-host frame receiver with clock glitch filter,
//             odd-parity/stop checking and an inter-edge timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_receiver #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kb_data,
    output logic       kb_hit,
    output logic       kb_err
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_DATA     = 2'd1;
    localparam logic [1:0]  c_PARITY   = 2'd2;
    localparam logic [1:0]  c_STOP     = 2'd3;
    localparam logic [3:0]  c_FILT_TOP = 4'(FILTER - 1);
    localparam logic [15:0] c_TMO_TOP  = 16'(TIMEOUT - 1);

    logic        r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic        r_filt;
    logic [3:0]  r_fcnt;
    logic [1:0]  r_state, w_state_nxt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [15:0] r_tcnt;
    logic        w_clk_diff, w_flip, w_fall, w_timeout;
    logic        w_hit_nxt, w_err_nxt;

    // Filtered clock only moves after FILTER consecutive disagreeing samples.
    assign w_clk_diff = (r_clk_s2 != r_filt);
    assign w_flip     = w_clk_diff && (r_fcnt == c_FILT_TOP);
    assign w_fall     = w_flip && r_filt;
    assign w_timeout  = (r_state != c_IDLE) && (r_tcnt == c_TMO_TOP) && !w_fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_filt   <= 1'b1;
            r_fcnt   <= 4'd0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
            if (w_flip) begin
                r_filt <= ~r_filt;
                r_fcnt <= 4'd0;
            end else if (w_clk_diff) begin
                r_fcnt <= r_fcnt + 4'd1;
            end else begin
                r_fcnt <= 4'd0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_IDLE:   if (w_fall && !r_dat_s2) w_state_nxt = c_DATA;
            c_DATA:   if (w_fall && (r_idx == 3'd7)) w_state_nxt = c_PARITY;
            c_PARITY: if (w_fall) w_state_nxt = c_STOP;
            c_STOP: begin
                if (w_fall) begin
                    w_state_nxt = c_IDLE;
                    // Odd parity over data plus parity bit, and stop bit high.
                    if (r_dat_s2 && (^{r_shift, r_par})) w_hit_nxt = 1'b1;
                    else                                 w_err_nxt = 1'b1;
                end
            end
            default:  w_state_nxt = c_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = c_IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_par   <= 1'b0;
            r_tcnt  <= 16'd0;
            kb_data <= 8'h00;
            kb_hit  <= 1'b0;
            kb_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            kb_hit  <= w_hit_nxt;
            kb_err  <= w_err_nxt;
            if (w_hit_nxt) kb_data <= r_shift;
            if (w_fall || (r_state == c_IDLE) || w_timeout) r_tcnt <= 16'd0;
            else                                             r_tcnt <= r_tcnt + 16'd1;
            if (w_fall) begin
                case (r_state)
                    c_IDLE:   r_idx <= 3'd0;
                    c_DATA: begin
                        r_shift[r_idx] <= r_dat_s2;
                        r_idx          <= r_idx + 3'd1;
                    end
                    c_PARITY: r_par <= r_dat_s2;
                    default:  r_idx <= 3'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_receiver
//  Purpose  : Scoreboard bench for ps2_receiver using directed PS/2 frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 1000;
    localparam int HALF    = 40;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] kb_data;
    logic       kb_hit;
    logic       kb_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         t_low = 0;
    int         last_err_cyc = 0;
    int         n_err_seen = 0;
    logic [7:0] model_data = 8'h00;
    logic       prev_strobe = 1'b0;

    ps2_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock  (clock),
        .reset  (reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .kb_data(kb_data),
        .kb_hit (kb_hit),
        .kb_err (kb_err)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_errors = n_errors + 1;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and tracks the held byte.
    always @(negedge clock) begin
        if (reset) begin
            model_data = 8'h00;
            check("reset_kb_data", {24'd0, kb_data}, 32'h00);
            check("reset_kb_hit", {31'd0, kb_hit}, 32'd0);
            check("reset_kb_err", {31'd0, kb_err}, 32'd0);
            prev_strobe = 1'b0;
        end else begin
            if (kb_hit || kb_err) begin
                check("strobes_exclusive", {31'd0, kb_hit && kb_err}, 32'd0);
                check("strobe_width", {31'd0, prev_strobe}, 32'd0);
                if (kb_err) begin
                    last_err_cyc = cyc;
                    n_err_seen   = n_err_seen + 1;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {31'd0, kb_hit}, {31'd0, ~kb_hit});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_kind_is_err", {31'd0, kb_err}, {31'd0, mon_e.is_err});
                    if (!mon_e.is_err) model_data = mon_e.data;
                end
            end
            check("kb_data_held", {24'd0, kb_data}, {24'd0, model_data});
            prev_strobe = kb_hit || kb_err;
        end
    end

    task automatic ps2_bit(input logic b, input logic glitch);
        @(negedge clock);
        ps2_dat = b;
        if (glitch) begin
            repeat (15) @(negedge clock);
            ps2_clk = 1'b0;
            repeat (5) @(negedge clock);
            ps2_clk = 1'b1;
            repeat (HALF - 20) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        ps2_clk = 1'b0;
        t_low   = cyc;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input int nbits, input logic glitch);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        @(negedge clock);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic expect_hit(input logic [7:0] d);
        exp_q.push_back('{is_err: 1'b0, data: d});
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, data: 8'h00});
    endtask

    initial begin
        int e0;
        int dly;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        repeat (20) @(negedge clock);

        expect_hit(8'h1C); send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        expect_hit(8'hF0); send(8'hF0, 1'b1, 1'b1, 11, 1'b0);
        expect_hit(8'h1C); send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        expect_err();      send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        expect_err();      send(8'hF0, 1'b1, 1'b0, 11, 1'b0);
        expect_hit(8'h3F); send(8'h3F, 1'b1, 1'b1, 11, 1'b1);

        // Start plus four data bits, then the lines idle high.
        e0 = n_err_seen;
        expect_err();
        send(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        for (int k = 0; k < 3 * TIMEOUT && n_err_seen == e0; k++) @(posedge clock);
        check("timeout_seen", {31'd0, n_err_seen != e0}, 32'd1);
        dly = last_err_cyc - t_low;
        check("timeout_latency_window",
              {31'd0, (dly >= TIMEOUT + FILTER) && (dly <= TIMEOUT + FILTER + 4)}, 32'd1);
        repeat (50) @(negedge clock);
        expect_hit(8'h1C); send(8'h1C, 1'b0, 1'b1, 11, 1'b0);

        // Partial 5Ah frame interrupted by a one-cycle reset.
        send(8'h5A, 1'b1, 1'b1, 7, 1'b0);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (20) @(negedge clock);
        expect_hit(8'h5A); send(8'h5A, 1'b1, 1'b1, 11, 1'b0);

        repeat (200) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
